frame_receiver: RTL

//  Serial frame deserializer, downstream of the frame transmitter (one bit per clk, same clock domain).

---
 rtl/frame_receiver_pkg.sv | 23 ++
 rtl/frame_receiver_if.sv | 28 ++
 rtl/frame_receiver_crc.sv | 27 ++
 rtl/frame_receiver.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/frame_receiver_pkg.sv
// Shared types and constants for the serial frame receiver.
package frame_receiver_pkg;

  // Receiver sequencing: start detect, 4 size bits, data bytes, CRC byte, stop bit.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIZE = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    STOP = 3'd4
  } rx_state_t;

  localparam logic       START_BIT = 1'b1;
  localparam logic       STOP_BIT  = 1'b0;
  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam int         MAX_BYTES = 16;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;
  localparam logic [1:0] ERR_STOP = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;

endpackage

// File: rtl/frame_receiver_if.sv
// Serial line plus decoded-frame outputs of the frame receiver.
// The line has no handshake: RX is sampled on every posedge. rf/err are
// one-cycle strobes; framesize/framebits/errcode are level outputs valid
// from the strobe until the next strobe. state is a debug view of the FSM.
interface frame_receiver_if;
  import frame_receiver_pkg::*;

  logic                     RX;
  logic                     busy;
  logic                     rf;
  logic                     err;
  logic [1:0]               errcode;
  logic [3:0]               framesize;
  logic [8*MAX_BYTES-1:0]   framebits;
  rx_state_t                state;

  // Line driver / result consumer side.
  modport master (
    output RX,
    input  busy, rf, err, errcode, framesize, framebits, state
  );

  // Receiver side.
  modport slave (
    input  RX,
    output busy, rf, err, errcode, framesize, framebits, state
  );
endinterface

// File: rtl/frame_receiver_crc.sv
// Running CRC-8 over a serial bit stream, MSb-first, init 0.
module frame_receiver_crc
  import frame_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_din,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_din ^ r_crc[7];
  assign o_crc = r_crc;

  // Shift one bit into the CRC when enabled; reset returns to the init value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc <= 8'h00;
    end else if (i_enable) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Serial frame deserializer: rebuilds size and payload, checks CRC and stop bit,
// and reports a good frame (rf) or an error (err/errcode).
module frame_receiver
  import frame_receiver_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  frame_receiver_if.slave         bus
);

  rx_state_t              r_state;
  logic [3:0]             r_size;
  logic [3:0]             r_bytecnt;
  logic [2:0]             r_bitcnt;
  logic [8*MAX_BYTES-1:0] r_work;
  logic [7:0]             r_rxcrc;
  logic                   r_rf;
  logic                   r_err;
  logic [1:0]             r_errcode;
  logic [3:0]             r_framesize;
  logic [8*MAX_BYTES-1:0] r_framebits;

  logic                   w_start;
  logic                   w_crc_en;
  logic                   w_crc_rst;
  logic [7:0]             w_crc;
  logic [3:0]             w_size_next;
  logic [6:0]             w_bit_idx;
  logic                   w_last_byte;

  assign w_start     = (r_state == IDLE) && (bus.RX == START_BIT);
  assign w_crc_en    = (r_state == SIZE) || (r_state == DATA);
  // A start bit restarts the CRC so each frame begins from the init value.
  assign w_crc_rst   = reset || w_start;
  assign w_size_next = {r_size[2:0], bus.RX};
  // Byte k, bit b lives at 8k+b, which is just the concatenation.
  assign w_bit_idx   = {r_bytecnt, r_bitcnt};
  // size <= 15, so byte+1 cannot wrap in 4 bits.
  assign w_last_byte = (4'(r_bytecnt + 4'd1) == r_size);

  frame_receiver_crc u_crc (
    .clk      (clk),
    .reset    (w_crc_rst),
    .i_enable (w_crc_en),
    .i_din    (bus.RX),
    .o_crc    (w_crc)
  );

  // Receive FSM; also owns the registered strobes and the held frame outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_size      <= 4'd0;
      r_bytecnt   <= 4'd0;
      r_bitcnt    <= 3'd0;
      r_work      <= '0;
      r_rxcrc     <= 8'h00;
      r_rf        <= 1'b0;
      r_err       <= 1'b0;
      r_errcode   <= ERR_NONE;
      r_framesize <= 4'd0;
      r_framebits <= '0;
    end else begin
      r_rf  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.RX == START_BIT) begin
            r_state  <= SIZE;
            r_work   <= '0;
            r_size   <= 4'd0;
            r_bitcnt <= 3'd3;
          end
        end
        SIZE: begin
          r_size <= w_size_next;
          if (r_bitcnt == 3'd0) begin
            if (w_size_next == 4'd0) begin
              r_state   <= IDLE;
              r_err     <= 1'b1;
              r_errcode <= ERR_SIZE;
            end else begin
              r_state   <= DATA;
              r_bytecnt <= 4'd0;
              r_bitcnt  <= 3'd7;
            end
          end else begin
            r_bitcnt <= r_bitcnt - 3'd1;
          end
        end
        DATA: begin
          r_work[w_bit_idx] <= bus.RX;
          if (r_bitcnt == 3'd0) begin
            r_bitcnt <= 3'd7;
            if (w_last_byte) begin
              r_state <= CRC;
            end else begin
              r_bytecnt <= r_bytecnt + 4'd1;
            end
          end else begin
            r_bitcnt <= r_bitcnt - 3'd1;
          end
        end
        CRC: begin
          r_rxcrc <= {r_rxcrc[6:0], bus.RX};
          if (r_bitcnt == 3'd0) begin
            r_state <= STOP;
          end else begin
            r_bitcnt <= r_bitcnt - 3'd1;
          end
        end
        STOP: begin
          r_state <= IDLE;
          // A bad stop bit outranks a CRC mismatch.
          if (bus.RX != STOP_BIT) begin
            r_err     <= 1'b1;
            r_errcode <= ERR_STOP;
          end else if (r_rxcrc != w_crc) begin
            r_err     <= 1'b1;
            r_errcode <= ERR_CRC;
          end else begin
            r_rf        <= 1'b1;
            r_errcode   <= ERR_NONE;
            r_framesize <= r_size;
            r_framebits <= r_work;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.rf        = r_rf;
  assign bus.err       = r_err;
  assign bus.errcode   = r_errcode;
  assign bus.framesize = r_framesize;
  assign bus.framebits = r_framebits;
  assign bus.state     = r_state;

endmodule
